// File: rtl/divider_pkg.sv
// divider_pkg: shared types and helpers for the sequential divider.
// Holds the FSM state encoding plus width and magnitude functions.
package divider_pkg;

    // Widest vector abs_val handles; covers 2*WIDTH for WIDTH <= 32.
    localparam int unsigned MAX_BITS = 128;

    typedef enum logic [1:0] {
        IDLE,
        WORK,
        RESTORE,
        FIX_SIGN
    } div_state_t;

    // Operand width N for the selected mode.
    function automatic int unsigned op_bits(
        input int unsigned width,
        input logic        half
    );
        return half ? width / 2 : width;
    endfunction

    // Bits needed for the iteration counter.
    function automatic int unsigned cnt_bits(
        input int unsigned width
    );
        return $clog2(width);
    endfunction

    // Two's-complement magnitude of v when neg is set.
    function automatic logic [MAX_BITS-1:0] abs_val(
        input logic [MAX_BITS-1:0] v,
        input logic                neg
    );
        return neg ? (~v + MAX_BITS'(1)) : v;
    endfunction

endpackage

// File: rtl/div_operand_prep.sv
// div_operand_prep: width select, magnitudes and fault detection.
// Purely combinational; feeds the divider FSM at acceptance.
module div_operand_prep
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               is_half,
    input  logic               is_signed,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0]   b_mag,
    output logic               div_zero,
    output logic               overflow,
    output logic               q_neg,
    output logic               r_neg
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned AW = 2 * WIDTH;

    logic          a_neg;
    logic          b_neg;
    logic [AW-1:0] a_ext;
    logic [W-1:0]  b_ext;
    logic [AW-1:0] b_wide;
    logic [AW-1:0] b_lim;
    int unsigned   nb;
    int unsigned   sh;

    // Extend the selected operands, take magnitudes and flag faults.
    always_comb begin
        nb = op_bits(W, is_half);
        if (is_half) begin
            a_neg = is_signed & dividend[W-1];
            b_neg = is_signed & divisor[H-1];
            a_ext = {{W{a_neg}}, dividend[W-1:0]};
            b_ext = {{H{b_neg}}, divisor[H-1:0]};
        end else begin
            a_neg = is_signed & dividend[AW-1];
            b_neg = is_signed & divisor[W-1];
            a_ext = dividend;
            b_ext = divisor;
        end
        a_mag = AW'(abs_val(MAX_BITS'(a_ext), a_neg));
        b_mag = W'(abs_val(MAX_BITS'(b_ext), b_neg));
        div_zero = (b_ext == '0);
        // Signed results must fit in N-1 magnitude bits.
        sh = is_signed ? nb - 1 : nb;
        b_wide = AW'(b_mag);
        b_lim = b_wide << sh;
        overflow = !div_zero && (a_mag >= b_lim);
        q_neg = a_neg ^ b_neg;
        r_neg = a_neg;
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle non-restoring divider, one quotient bit
// per cycle, for DIV/IDIV at full or half operand width.
module seq_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_half,
    input  logic               is_signed,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               complete,
    output logic               err_div_zero,
    output logic               err_overflow,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned PW = 4 * WIDTH;
    localparam int unsigned CW = cnt_bits(WIDTH);

    localparam logic [W-1:0] HALF_MASK = {{H{1'b0}}, {H{1'b1}}};

    div_state_t    state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [PW-1:0] d_q, d_d;
    logic [W-1:0]  qb_q, qb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          half_q, half_d;
    logic          sgn_q, sgn_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          cmp_q, cmp_d;
    logic          edz_q, edz_d;
    logic          eov_q, eov_d;

    logic [AW-1:0] a_mag;
    logic [W-1:0]  b_mag;
    logic          pre_dz;
    logic          pre_ov;
    logic          pre_qneg;
    logic          pre_rneg;

    logic [PW-1:0] p_dbl;
    logic [PW-1:0] p_fix;
    logic [W-1:0]  q_fix;
    logic [W-1:0]  q_mask;
    logic [W-1:0]  r_mag;
    int unsigned   nb_new;
    int unsigned   nb_cur;

    div_operand_prep #(
        .WIDTH(WIDTH)
    ) u_prep (
        .is_half  (is_half),
        .is_signed(is_signed),
        .dividend (dividend),
        .divisor  (divisor),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .div_zero (pre_dz),
        .overflow (pre_ov),
        .q_neg    (pre_qneg),
        .r_neg    (pre_rneg)
    );

    assign busy = (start && state_q == IDLE) || (state_q != IDLE);
    assign complete     = cmp_q;
    assign err_div_zero = edz_q;
    assign err_overflow = eov_q;
    assign quotient     = quot_q;
    assign remainder    = rem_q;

    // Next-state, iteration step, correction and sign fix.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        d_d     = d_q;
        qb_d    = qb_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cmp_d   = 1'b0;
        edz_d   = edz_q;
        eov_d   = eov_q;
        nb_new  = op_bits(W, is_half);
        nb_cur  = op_bits(W, half_q);
        p_dbl   = p_q << 1;
        p_fix   = p_q;
        q_mask  = half_q ? HALF_MASK : '1;
        q_fix   = '0;
        r_mag   = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    edz_d = pre_dz;
                    eov_d = pre_ov;
                    if (pre_dz || pre_ov) begin
                        cmp_d = 1'b1;
                    end else begin
                        state_d = WORK;
                        p_d     = PW'(a_mag);
                        d_d     = PW'(b_mag) << nb_new;
                        qb_d    = '0;
                        cnt_d   = CW'(nb_new - 1);
                        half_d  = is_half;
                        sgn_d   = is_signed;
                        qneg_d  = pre_qneg;
                        rneg_d  = pre_rneg;
                    end
                end
            end
            WORK: begin
                if (p_q[PW-1]) begin
                    p_d = p_dbl + d_q;
                end else begin
                    p_d = p_dbl - d_q;
                    qb_d[cnt_q] = 1'b1;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = RESTORE;
                end
            end
            RESTORE: begin
                // Digits are +1/-1; map to binary, fix a negative tail.
                q_fix = (qb_q - ~qb_q - W'(p_q[PW-1])) & q_mask;
                if (p_q[PW-1]) begin
                    p_fix = p_q + d_q;
                end
                r_mag = W'(p_fix >> nb_cur);
                cnt_d = '0;
                if (sgn_q) begin
                    qb_d    = q_fix;
                    p_d     = PW'(r_mag);
                    state_d = FIX_SIGN;
                end else begin
                    quot_d  = q_fix;
                    rem_d   = r_mag;
                    p_d     = '0;
                    cmp_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            FIX_SIGN: begin
                // Magnitudes fit in N-1 bits, so a W-bit negate
                // also sign-extends half-width results.
                quot_d  = qneg_q ? (~qb_q + W'(1)) : qb_q;
                rem_d   = rneg_q ? (~p_q[W-1:0] + W'(1))
                                 : p_q[W-1:0];
                p_d     = '0;
                cmp_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            d_q     <= '0;
            qb_q    <= '0;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            cmp_q   <= 1'b0;
            edz_q   <= 1'b0;
            eov_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            d_q     <= d_d;
            qb_q    <= qb_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cmp_q   <= cmp_d;
            edz_q   <= edz_d;
            eov_q   <= eov_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: seq_divider (WIDTH=16) against an arithmetic
// reference model, with directed literal cases and a random sweep.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_half;
    logic        is_signed;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        complete;
    logic        err_div_zero;
    logic        err_overflow;
    logic [15:0] quotient;
    logic [15:0] remainder;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int e0      = 0;
    bit armed   = 0;

    // model state
    logic        pend = 1'b0;
    int          done_e = 0;
    int          rst_e = -1;
    logic [15:0] pq, pr;
    logic [15:0] hq = '0;
    logic [15:0] hr = '0;
    logic        pdz, pov;

    logic [31:0] rnd_a;
    logic [15:0] rnd_b;

    seq_divider #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_half     (is_half),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .complete    (complete),
        .err_div_zero(err_div_zero),
        .err_overflow(err_overflow),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // x86 DIV/IDIV semantics with plain integer arithmetic.
    function automatic void ref_div(
        input  logic [31:0] dvd,
        input  logic [15:0] dvs,
        input  logic        half,
        input  logic        sgn,
        output logic        dz,
        output logic        ov,
        output logic [15:0] q,
        output logic [15:0] r,
        output int          lat
    );
        int     n;
        longint a, b, am, bm, qa, ra;
        n = half ? 8 : 16;
        if (half && sgn) begin
            a = longint'($signed(dvd[15:0]));
            b = longint'($signed(dvs[7:0]));
        end else if (half) begin
            a = longint'(dvd[15:0]);
            b = longint'(dvs[7:0]);
        end else if (sgn) begin
            a = longint'($signed(dvd));
            b = longint'($signed(dvs));
        end else begin
            a = longint'(dvd);
            b = longint'(dvs);
        end
        am = (a < 0) ? -a : a;
        bm = (b < 0) ? -b : b;
        dz = (b == 0);
        ov = 1'b0;
        if (!dz) begin
            if (sgn) ov = (am >= (bm << (n - 1)));
            else     ov = (a >= (b << n));
        end
        q = '0;
        r = '0;
        if (!dz && !ov) begin
            qa = a / b;
            ra = a % b;
            q  = qa[15:0];
            r  = ra[15:0];
        end
        lat = (dz || ov) ? 0 : n + 1 + (sgn ? 1 : 0);
    endfunction

    // Model update on each edge, compare on the following negedge.
    initial begin
        int lat_m;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                pend  = 1'b0;
                hq    = '0;
                hr    = '0;
                rst_e = cyc;
                armed = 1'b1;
            end else begin
                if (pend && done_e == cyc && !pdz && !pov) begin
                    hq = pq;
                    hr = pr;
                end
                if (start && (!pend || cyc > done_e)) begin
                    ref_div(dividend, divisor, is_half, is_signed,
                            pdz, pov, pq, pr, lat_m);
                    pend   = 1'b1;
                    done_e = cyc + lat_m;
                end
            end
            @(negedge clk);
            if (armed) begin
                check("complete", complete, pend && done_e == cyc);
                check("busy", busy, (pend && cyc < done_e) || start);
                check("quotient", quotient, hq);
                check("remainder", remainder, hr);
                if (pend && done_e == cyc) begin
                    check("err_div_zero", err_div_zero, pdz);
                    check("err_overflow", err_overflow, pov);
                end
                if (rst_e == cyc) begin
                    check("rst_dz", err_div_zero, 0);
                    check("rst_ov", err_overflow, 0);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] dvd, input logic [15:0] dvs,
                         input logic h, input logic s);
        dividend  = dvd;
        divisor   = dvs;
        is_half   = h;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        e0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit got;
        got = 0;
        lat = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (complete === 1'b1) begin
                lat = cyc - e0;
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no complete within 64 cycles");
        end
    endtask

    task automatic run(input string nm,
                       input logic [31:0] dvd, input logic [15:0] dvs,
                       input logic h, input logic s,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edz, input logic eov, input int elat);
        int lat;
        issue(dvd, dvs, h, s);
        wait_done(lat);
        check({nm, "_lat"}, lat, elat);
        check({nm, "_q"}, quotient, eq);
        check({nm, "_r"}, remainder, er);
        check({nm, "_dz"}, err_div_zero, edz);
        check({nm, "_ov"}, err_overflow, eov);
        sync();
    endtask

    initial begin
        logic        mdz, mov;
        logic [15:0] mq, mr;
        int          mlat;
        int          lat;

        reset = 1'b1; start = 1'b0; is_half = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;

        // pin the model with hand-worked values
        ref_div(32'h00010005, 16'h0002, 0, 0, mdz, mov, mq, mr, mlat);
        check("model_udiv_q", mq, 16'h8002);
        check("model_udiv_lat", mlat, 17);
        ref_div(32'hFFFFFFF9, 16'h0002, 0, 1, mdz, mov, mq, mr, mlat);
        check("model_sdiv_r", mr, 16'hFFFF);
        ref_div(32'h0000FF80, 16'h0001, 1, 1, mdz, mov, mq, mr, mlat);
        check("model_sovf", mov, 1);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("init_q", quotient, 16'h0);
        check("init_busy", busy, 0);
        sync();

        run("udiv", 32'h00010005, 16'h0002, 0, 0,
            16'h8002, 16'h0001, 0, 0, 17);
        run("sdiv", 32'hFFFFFFF9, 16'h0002, 0, 1,
            16'hFFFD, 16'hFFFF, 0, 0, 18);
        run("shalf", 32'h0000FF80, 16'h0002, 1, 1,
            16'hFFC0, 16'h0000, 0, 0, 10);
        run("dz", 32'h00001234, 16'h0000, 0, 0,
            16'hFFC0, 16'h0000, 1, 0, 0);
        run("uovf", 32'h00020000, 16'h0002, 0, 0,
            16'hFFC0, 16'h0000, 0, 1, 0);
        run("sovf_h", 32'h0000FF80, 16'h0001, 1, 1,
            16'hFFC0, 16'h0000, 0, 1, 0);
        run("dz_h", 32'h00000010, 16'h0100, 1, 0,
            16'hFFC0, 16'h0000, 1, 0, 0);
        run("sovf_f", 32'hFFFF8000, 16'h0001, 0, 1,
            16'hFFC0, 16'h0000, 0, 1, 0);
        run("umax", 32'hFFFEFFFF, 16'hFFFF, 0, 0,
            16'hFFFF, 16'hFFFE, 0, 0, 17);

        // reset in the middle of WORK
        issue(32'h00010005, 16'h0002, 0, 0);
        repeat (4) sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_q", quotient, 16'h0);
        check("midrst_r", remainder, 16'h0);
        check("midrst_cmp", complete, 0);
        check("midrst_busy", busy, 0);
        sync();
        run("after_rst", 32'hABCD1234, 16'hFF56, 1, 0,
            16'h0036, 16'h0010, 0, 0, 9);

        // back-to-back: second start in the complete cycle
        issue(32'h00000064, 16'h0007, 0, 0);
        repeat (17) sync();
        check("b2b_a_cmp", complete, 1);
        check("b2b_a_q", quotient, 16'h000E);
        check("b2b_a_r", remainder, 16'h0002);
        issue(32'h00000064, 16'hFFF9, 0, 1);
        wait_done(lat);
        check("b2b_b_lat", lat, 18);
        check("b2b_b_q", quotient, 16'hFFF2);
        check("b2b_b_r", remainder, 16'h0002);
        sync();

        // start and operand changes during WORK are ignored
        issue(32'h0000FFFF, 16'h0010, 0, 0);
        repeat (3) sync();
        dividend = '0;
        divisor  = '0;
        start    = 1'b1;
        sync();
        start = 1'b0;
        wait_done(lat);
        check("ign_lat", lat, 17);
        check("ign_q", quotient, 16'h0FFF);
        check("ign_r", remainder, 16'h000F);
        sync();

        // random sweep over both widths and signedness
        for (int i = 0; i < 48; i++) begin
            rnd_a = $urandom;
            rnd_b = 16'($urandom);
            if (i % 3 == 0) rnd_a = rnd_a >> 17;
            if (i % 5 == 0) rnd_a = {16'hFFFF, rnd_a[15:0]};
            issue(rnd_a, rnd_b, i[0], i[1]);
            wait_done(lat);
            sync();
        end

        repeat (2) sync();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
